// File: rtl/shift_derecha_secuencial_if.sv
// Request/result bundle for the multi-cycle right shifter.
//   Inicio     : start request, only looked at while the shifter is idle
//   Original   : 32-bit operand, captured on accept
//   Cantidad   : shift amount 0..31, captured on accept
//   Aritmetico : 1 = SRA (sign fill), 0 = SRL (zero fill), captured on accept
//   Nuevo      : result register, held until the next accept
//   Listo      : one-cycle done pulse
//   Ocupado    : operation in progress
// master = requester (ALU side), slave = shifter.
interface shift_derecha_secuencial_if;
  logic        Inicio;
  logic [31:0] Original;
  logic [4:0]  Cantidad;
  logic        Aritmetico;
  logic [31:0] Nuevo;
  logic        Listo;
  logic        Ocupado;

  modport master (
    output Inicio, Original, Cantidad, Aritmetico,
    input  Nuevo, Listo, Ocupado
  );

  modport slave (
    input  Inicio, Original, Cantidad, Aritmetico,
    output Nuevo, Listo, Ocupado
  );
endinterface

// File: rtl/shift_derecha_secuencial.sv
// Multi-cycle 32-bit right shifter (SRL / SRA).
// Accepts an operand, a 5-bit amount and a mode on Inicio while idle, then
// shifts one bit per cycle until the amount is used up and pulses Listo.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : shift_derecha_secuencial_if.slave (request in, result/status out)
// Build option:
//   SHIFT_DERECHA_RAPIDO_EN : when defined, shift by 4 per cycle while at
//   least 4 positions remain, then finish 1 bit at a time. Results are
//   identical, only latency changes.
module shift_derecha_secuencial (
  input  logic                           clk,
  input  logic                           reset,
  shift_derecha_secuencial_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] nuevo, nuevo_n;
  logic [4:0]  cnt, cnt_n;
  logic        arit, arit_n;
  logic        listo, ocupado;
  logic        fill;

  // Sign fill comes from the current MSB; since every step refills with that
  // same bit, the original sign is preserved across iterations.
  assign fill = arit & nuevo[31];

  always_comb begin
    state_n = state;
    nuevo_n = nuevo;
    cnt_n   = cnt;
    arit_n  = arit;
    case (state)
      IDLE: begin
        if (bus.Inicio) begin
          nuevo_n = bus.Original;
          cnt_n   = bus.Cantidad;
          arit_n  = bus.Aritmetico;
          state_n = (bus.Cantidad == 5'd0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef SHIFT_DERECHA_RAPIDO_EN
        if (cnt >= 5'd4) begin
          nuevo_n = {{4{fill}}, nuevo[31:4]};
          cnt_n   = cnt - 5'd4;
        end else begin
          nuevo_n = {fill, nuevo[31:1]};
          cnt_n   = cnt - 5'd1;
        end
`else
        nuevo_n = {fill, nuevo[31:1]};
        cnt_n   = cnt - 5'd1;
`endif
        if (cnt_n == 5'd0) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      nuevo <= '0;
      cnt   <= '0;
      arit  <= 1'b0;
    end else begin
      state <= state_n;
      nuevo <= nuevo_n;
      cnt   <= cnt_n;
      arit  <= arit_n;
    end
  end

  // Status flags are registered from the next state so they line up with
  // the state they describe without any input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      listo   <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      listo   <= (state_n == DONE);
      ocupado <= (state_n != IDLE);
    end
  end

  assign bus.Nuevo   = nuevo;
  assign bus.Listo   = listo;
  assign bus.Ocupado = ocupado;

endmodule
